// File: rtl/uart_imem_loader_if.sv
// Bundle between the UART receiver, the loader and the IMEM write port, plus loader status.
// The loader is the slave of the byte stream and drives the write port and status.
interface uart_imem_loader_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic [15:0] words_loaded;
    logic        load_busy;
    logic        load_done;
    logic        load_error;
    logic        cpu_reset;

    modport master (
        output rx_data, rx_valid,
        input  imem_we, imem_addr, imem_wdata, words_loaded,
        input  load_busy, load_done, load_error, cpu_reset
    );

    modport slave (
        input  rx_data, rx_valid,
        output imem_we, imem_addr, imem_wdata, words_loaded,
        output load_busy, load_done, load_error, cpu_reset
    );
endinterface

// File: rtl/uart_imem_loader.sv
// Receives a length-prefixed program image over the UART byte stream and writes it into IMEM,
// holding the CPU in reset until the whole image has been written.
module uart_imem_loader #(
    parameter int unsigned DEPTH     = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int unsigned TIMEOUT   = 100000
) (
    input logic               clk,
    input logic               reset,
    uart_imem_loader_if.slave bus
);
    localparam logic [31:0] TmoLast = 32'(TIMEOUT - 1);
    localparam logic [31:0] DepthW  = 32'(DEPTH);

    typedef enum logic [2:0] {StIdle, StLenLo, StData, StDone, StErr} state_e;

    state_e      state_q, state_d;
    logic [15:0] len_q, len_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [23:0] shift_q, shift_d;
    logic [31:0] tmo_q, tmo_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [15:0] words_q, words_d;

    logic [15:0] len_rx;
    logic        tmo_hit;

    assign len_rx  = {len_q[15:8], bus.rx_data};
    // An arriving byte always beats an expiring counter.
    assign tmo_hit = !bus.rx_valid && (tmo_q == TmoLast);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (bus.rx_valid) state_d = StLenLo;
            end
            StLenLo: begin
                if (bus.rx_valid) begin
                    if (len_rx == 16'h0)                 state_d = StDone;
                    else if ({16'h0, len_rx} > DepthW)   state_d = StErr;
                    else                                 state_d = StData;
                end else if (tmo_hit) begin
                    state_d = StErr;
                end
            end
            StData: begin
                // Leave only after the final write pulse has been presented.
                if (we_q && (words_q == len_q)) state_d = StDone;
                else if (tmo_hit)               state_d = StErr;
            end
            default: state_d = state_q;
        endcase
    end

    always_comb begin
        bus.load_busy  = (state_q == StLenLo) || (state_q == StData);
        bus.load_done  = (state_q == StDone);
        bus.load_error = (state_q == StErr);
        bus.cpu_reset  = (state_q != StDone);
        bus.imem_we      = we_q;
        bus.imem_addr    = addr_q;
        bus.imem_wdata   = wdata_q;
        bus.words_loaded = words_q;
    end

    always_comb begin
        len_d      = len_q;
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        tmo_d      = '0;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        words_d    = words_q;
        if ((state_q == StLenLo) || (state_q == StData)) begin
            tmo_d = bus.rx_valid ? 32'h0 : tmo_q + 32'h1;
        end
        if (bus.rx_valid) begin
            if (state_q == StIdle)  len_d[15:8] = bus.rx_data;
            if (state_q == StLenLo) len_d[7:0]  = bus.rx_data;
            if (state_q == StData) begin
                if (byte_cnt_q == 2'd3) begin
                    we_d    = 1'b1;
                    wdata_d = {shift_q, bus.rx_data};
                    addr_d  = BASE_ADDR + {14'h0, words_q, 2'b00};
                    words_d = words_q + 16'h1;
                end else begin
                    shift_d = {shift_q[15:0], bus.rx_data};
                end
                byte_cnt_d = byte_cnt_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            len_q      <= '0;
            byte_cnt_q <= '0;
            shift_q    <= '0;
            tmo_q      <= '0;
            we_q       <= 1'b0;
            addr_q     <= BASE_ADDR;
            wdata_q    <= '0;
            words_q    <= '0;
        end else begin
            len_q      <= len_d;
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
            tmo_q      <= tmo_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            words_q    <= words_d;
        end
    end
endmodule

// File: tb/tb_uart_imem_loader.sv
// Scoreboard bench for uart_imem_loader: frames are built from random words, expected writes
// (address, data, cycle) are queued by the driver and popped by a negedge monitor.
module tb_uart_imem_loader;
    localparam int unsigned DEPTH   = 256;
    localparam int unsigned TIMEOUT = 16;
    localparam logic [31:0] BASE    = 32'h0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    uart_imem_loader_if bus();

    uart_imem_loader #(
        .DEPTH    (DEPTH),
        .BASE_ADDR(BASE),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    wr_t exp_q[$];
    logic [31:0] frame_w[$];
    logic prev_we = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every write pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) begin
            wr_t e;
            check("we_single_cycle", {31'h0, prev_we}, 32'h0);
            if (exp_q.size() == 0) begin
                check("unexpected_write_addr", bus.imem_addr, 32'hxxxx_xxxx);
            end else begin
                e = exp_q.pop_front();
                check("write_addr", bus.imem_addr, e.addr);
                check("write_data", bus.imem_wdata, e.data);
                check("write_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
        prev_we = bus.imem_we;
    end

    task automatic send_byte(input logic [7:0] b);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'($urandom);
    endtask

    task automatic gap(input int max_gap);
        repeat ($urandom_range(max_gap, 0)) @(negedge clk);
    endtask

    // Reference: words 0..N-1 land at BASE+4i one cycle after their 4th byte, only for 0<N<=DEPTH.
    task automatic send_frame(input int n, input int nw, input int max_gap);
        bit ok;
        logic [31:0] w;
        ok = (n > 0) && (n <= int'(DEPTH));
        gap(max_gap);
        send_byte(8'(n >> 8));
        gap(max_gap);
        send_byte(8'(n));
        for (int i = 0; i < nw; i++) begin
            w = frame_w[i];
            for (int j = 0; j < 4; j++) begin
                gap(max_gap);
                if (j == 3 && ok && i < n) exp_q.push_back('{BASE + 32'(4 * i), w, cyc + 1});
                send_byte(w[31 - 8 * j -: 8]);
            end
        end
    endtask

    task automatic rand_words(input int nw);
        frame_w.delete();
        for (int i = 0; i < nw; i++) frame_w.push_back($urandom);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.rx_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic check_status(input string tag, input bit done, input bit err, input bit busy,
                                input bit cpu_rst, input int words);
        check({tag, ".load_done"}, {31'h0, bus.load_done}, {31'h0, done});
        check({tag, ".load_error"}, {31'h0, bus.load_error}, {31'h0, err});
        check({tag, ".load_busy"}, {31'h0, bus.load_busy}, {31'h0, busy});
        check({tag, ".cpu_reset"}, {31'h0, bus.cpu_reset}, {31'h0, cpu_rst});
        check({tag, ".words_loaded"}, {16'h0, bus.words_loaded}, 32'(words));
    endtask

    initial begin
        int n;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h0;
        @(negedge clk);
        do_reset();
        check("reset.imem_we", {31'h0, bus.imem_we}, 32'h0);
        check("reset.imem_addr", bus.imem_addr, BASE);
        check("reset.imem_wdata", bus.imem_wdata, 32'h0);
        check_status("reset", 1'b0, 1'b0, 1'b0, 1'b1, 0);

        // Directed two-word image.
        frame_w = '{32'h2004_0005, 32'h0000_1026};
        send_frame(2, 2, 3);
        @(negedge clk);
        check_status("two_words", 1'b1, 1'b0, 1'b0, 1'b0, 2);
        check("hold.imem_addr", bus.imem_addr, BASE + 32'h4);
        check("hold.imem_wdata", bus.imem_wdata, 32'h0000_1026);

        // Zero length completes straight away.
        do_reset();
        send_frame(0, 0, 2);
        check_status("zero_len", 1'b1, 1'b0, 1'b0, 1'b0, 0);

        // Oversize length errors; later bytes must not write.
        do_reset();
        rand_words(3);
        send_frame(257, 3, 2);
        check_status("too_long", 1'b0, 1'b1, 1'b0, 1'b1, 0);

        // Inter-byte timeout fires exactly TIMEOUT cycles after the last byte.
        do_reset();
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'hAA);
        send_byte(8'hBB);
        repeat (TIMEOUT - 1) @(negedge clk);
        check_status("tmo_before", 1'b0, 1'b0, 1'b1, 1'b1, 0);
        @(negedge clk);
        check_status("tmo_fired", 1'b0, 1'b1, 1'b0, 1'b1, 0);

        // A byte coincident with expiry wins and the frame completes.
        do_reset();
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'hAA);
        send_byte(8'hBB);
        repeat (TIMEOUT - 1) @(negedge clk);
        send_byte(8'hCC);
        check("tmo_rescued.load_error", {31'h0, bus.load_error}, 32'h0);
        exp_q.push_back('{BASE, 32'hAABB_CCDD, cyc + 1});
        send_byte(8'hDD);
        @(negedge clk);
        check_status("tmo_rescued", 1'b1, 1'b0, 1'b0, 1'b0, 1);

        // Reset mid-frame, then a fresh single-word image.
        do_reset();
        rand_words(2);
        send_frame(3, 2, 2);
        repeat (2) @(negedge clk);
        check("midframe.pending", 32'(exp_q.size()), 32'h0);
        check_status("midframe", 1'b0, 1'b0, 1'b1, 1'b1, 2);
        do_reset();
        check_status("midframe_reset", 1'b0, 1'b0, 1'b0, 1'b1, 0);
        frame_w = '{32'hDEAD_BEEF};
        send_frame(1, 1, 2);
        @(negedge clk);
        check_status("deadbeef", 1'b1, 1'b0, 1'b0, 1'b0, 1);

        // Back-to-back bytes, then trailing bytes after DONE must be ignored.
        do_reset();
        rand_words(4);
        send_frame(4, 4, 0);
        @(negedge clk);
        check_status("b2b", 1'b1, 1'b0, 1'b0, 1'b0, 4);
        for (int i = 0; i < 8; i++) send_byte(8'($urandom));
        check_status("after_done", 1'b1, 1'b0, 1'b0, 1'b0, 4);

        // Random images with random gaps.
        for (int k = 0; k < 6; k++) begin
            do_reset();
            n = $urandom_range(12, 1);
            rand_words(n);
            send_frame(n, n, 8);
            @(negedge clk);
            check_status("random", 1'b1, 1'b0, 1'b0, 1'b0, n);
        end

        repeat (4) @(negedge clk);
        check("final.pending", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
